// File: rtl/int_branch_recovery_arbiter.sv
// Picks the oldest mispredicted branch across the integer lanes, presents it to the
// recovery manager over req/ack, and tracks the single in-flight recovery to completion.
module int_branch_recovery_arbiter #(
    parameter int ISSUE_WIDTH  = 2,
    parameter int AL_PTR_WIDTH = 6,
    parameter int PC_WIDTH     = 32,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [AL_PTR_WIDTH-1:0]             head_ptr,
    input  logic [ISSUE_WIDTH-1:0]              br_valid,
    input  logic [ISSUE_WIDTH-1:0]              br_mispred,
    input  logic [ISSUE_WIDTH*AL_PTR_WIDTH-1:0] br_al_ptr,
    input  logic [ISSUE_WIDTH*PC_WIDTH-1:0]     br_next_addr,
    input  logic                                flush_all,
    input  logic                                rec_ack,
    input  logic                                rec_done,
    output logic                                rec_req,
    output logic [AL_PTR_WIDTH-1:0]             rec_al_ptr,
    output logic [PC_WIDTH-1:0]                 rec_next_addr,
    output logic                                busy,
    output logic [CNT_WIDTH-1:0]                drop_count
);

    localparam int NW = $clog2(ISSUE_WIDTH + 1);

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_PENDING    = 2'd1;
    localparam logic [1:0] ST_RECOVERING = 2'd2;

    logic                    pend_valid_q, pend_valid_d;
    logic [AL_PTR_WIDTH-1:0] pend_ptr_q,   pend_ptr_d;
    logic [PC_WIDTH-1:0]     pend_addr_q,  pend_addr_d;
    logic                    infl_valid_q, infl_valid_d;
    logic [AL_PTR_WIDTH-1:0] infl_ptr_q,   infl_ptr_d;
    logic [CNT_WIDTH-1:0]    drop_cnt_q,   drop_cnt_d;

    logic [1:0]              state;
    logic                    ack_fire;
    logic                    done_fire;

    logic                    win_found;
    logic [AL_PTR_WIDTH-1:0] win_ptr;
    logic [AL_PTR_WIDTH-1:0] win_age;
    logic [PC_WIDTH-1:0]     win_addr;
    logic [AL_PTR_WIDTH-1:0] lane_ptr;
    logic [AL_PTR_WIDTH-1:0] lane_age;
    logic [NW-1:0]           num_cand;

    logic [AL_PTR_WIDTH-1:0] pend_age;
    logic [AL_PTR_WIDTH-1:0] infl_age;
    logic                    win_accept;
    logic [NW-1:0]           num_drop;
    logic [CNT_WIDTH:0]      cnt_sum;

    // The state is fully implied by the two slot valid bits.
    always_comb begin
        if (infl_valid_q)      state = ST_RECOVERING;
        else if (pend_valid_q) state = ST_PENDING;
        else                   state = ST_IDLE;
    end

    assign ack_fire  = (state == ST_PENDING) && rec_ack;
    assign done_fire = (state == ST_RECOVERING) && rec_done;

    // NOTE: every combinational output gets a default first so no latch is inferred;
    // blocking assignments let the loop carry the running winner across lanes.
    always_comb begin
        win_found = 1'b0;
        win_ptr   = '0;
        win_age   = '0;
        win_addr  = '0;
        lane_ptr  = '0;
        lane_age  = '0;
        num_cand  = '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            if (br_valid[i] && br_mispred[i]) begin
                lane_ptr = br_al_ptr[i*AL_PTR_WIDTH +: AL_PTR_WIDTH];
                lane_age = lane_ptr - head_ptr;
                num_cand = num_cand + NW'(1);
                // Strict compare keeps the lower lane on an age tie.
                if (!win_found || (lane_age < win_age)) begin
                    win_found = 1'b1;
                    win_ptr   = lane_ptr;
                    win_age   = lane_age;
                    win_addr  = br_next_addr[i*PC_WIDTH +: PC_WIDTH];
                end
            end
        end
    end

    assign pend_age   = pend_ptr_q - head_ptr;
    assign infl_age   = infl_ptr_q - head_ptr;
    assign win_accept = win_found
                     && (!pend_valid_q || (win_age < pend_age))
                     && (!infl_valid_q || (win_age < infl_age));
    assign num_drop   = num_cand - NW'(win_accept);
    assign cnt_sum    = {1'b0, drop_cnt_q} + (CNT_WIDTH+1)'(num_drop);

    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_ptr_d   = pend_ptr_q;
        pend_addr_d  = pend_addr_q;
        infl_valid_d = infl_valid_q;
        infl_ptr_d   = infl_ptr_q;
        drop_cnt_d   = drop_cnt_q;
        if (flush_all) begin
            pend_valid_d = 1'b0;
            pend_ptr_d   = '0;
            pend_addr_d  = '0;
            infl_valid_d = 1'b0;
            infl_ptr_d   = '0;
        end else begin
            if (done_fire) begin
                infl_valid_d = 1'b0;
                infl_ptr_d   = '0;
            end
            if (ack_fire) begin
                infl_valid_d = 1'b1;
                infl_ptr_d   = pend_ptr_q;
                pend_valid_d = 1'b0;
                pend_ptr_d   = '0;
                pend_addr_d  = '0;
            end
            // An accepted winner is older than the acked entry, so it may reload pend.
            if (win_accept) begin
                pend_valid_d = 1'b1;
                pend_ptr_d   = win_ptr;
                pend_addr_d  = win_addr;
            end
            drop_cnt_d = cnt_sum[CNT_WIDTH] ? '1 : cnt_sum[CNT_WIDTH-1:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_valid_q <= 1'b0;
            pend_ptr_q   <= '0;
            pend_addr_q  <= '0;
            infl_valid_q <= 1'b0;
            infl_ptr_q   <= '0;
            drop_cnt_q   <= '0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_ptr_q   <= pend_ptr_d;
            pend_addr_q  <= pend_addr_d;
            infl_valid_q <= infl_valid_d;
            infl_ptr_q   <= infl_ptr_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    // Pend fields are zeroed whenever the slot empties, so they drive rec_* directly.
    assign rec_req       = (state == ST_PENDING);
    assign rec_al_ptr    = pend_ptr_q;
    assign rec_next_addr = pend_addr_q;
    assign busy          = infl_valid_q;
    assign drop_count    = drop_cnt_q;

endmodule

// File: doc/int_branch_recovery_arbiter.md
# int_branch_recovery_arbiter

Selects the oldest mispredicted branch among the integer execution lanes each cycle. Holds it as a registered recovery request to the recovery manager with a req/ack handshake, then tracks the in-flight recovery until completion. Sits between the integer execution stage branch-result outputs and the recovery manager. Older mispredicts that resolve later preempt a pending request. Younger ones are dropped, since the recovery squashes them.

## Interface
- ISSUE_WIDTH, 2: number of integer lanes.
- AL_PTR_WIDTH, 6: active-list pointer width; list depth is 2^AL_PTR_WIDTH.
- PC_WIDTH, 32: recovery target address width.
- CNT_WIDTH, 16: drop-counter width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- head_ptr  in  AL_PTR_WIDTH  active-list head (oldest op); age reference
- br_valid  in  ISSUE_WIDTH  lane i has a valid resolved branch this cycle
- br_mispred  in  ISSUE_WIDTH  lane i branch mispredicted
- br_al_ptr  in  ISSUE_WIDTH*AL_PTR_WIDTH  lane i active-list pointer, lane 0 in LSBs
- br_next_addr  in  ISSUE_WIDTH*PC_WIDTH  lane i correct next PC
- flush_all  in  1  global flush (exception/trap); discards all state
- rec_ack  in  1  recovery manager accepts rec_req
- rec_done  in  1  single-cycle pulse: in-flight recovery finished
- rec_req  out  1  recovery request valid
- rec_al_ptr  out  AL_PTR_WIDTH  pointer of the branch to recover at
- rec_next_addr  out  PC_WIDTH  fetch redirect address
- busy  out  1  recovery in flight (ack taken, done not yet seen)
- drop_count  out  CNT_WIDTH  saturating count of dropped mispredicts

## Operation
- Candidate: lane i is a candidate when br_valid[i] && br_mispred[i].
- Age: age(p) = (p - head_ptr) mod 2^AL_PTR_WIDTH. Smaller age is older.
- Lane pick: the candidate with the smallest age wins. On equal age, the lower lane index wins.
- Registers:
  - pend slot: valid, ptr, addr. Drives rec_*.
  - inflight slot: valid, ptr.
  - drop_count.
- States:
  - IDLE: no pend, no inflight.
  - PENDING: pend valid, no inflight.
  - RECOVERING: inflight valid; pend may also be valid.
- Winner acceptance: the lane winner W is compared against the ages of the registered slots, using the current head_ptr.
  - Stored into pend when no slot is valid.
  - Stored into pend when W is older than every valid slot (pend and/or inflight).
  - Otherwise dropped; drop_count += 1.
  - Losing lane candidates each also count as drops.
  - drop_count increments by the number of dropped candidates that cycle and saturates at all-ones.
- Transitions:
  - IDLE -> PENDING on an accepted winner.
  - PENDING -> RECOVERING on rec_req && rec_ack: pend moves to inflight and pend is cleared. If an older winner arrives in the same cycle, it loads pend, since it is older than the acked one.
  - PENDING, winner older than pend without ack: pend is overwritten (preemption); rec_* change the next cycle.
  - RECOVERING + rec_done: inflight is cleared. Next state is PENDING if pend is valid, else IDLE.
  - rec_done outside RECOVERING is ignored.
- rec_req = pend valid && !inflight valid. Only one recovery is in flight at a time. rec_al_ptr/rec_next_addr = pend fields; they are 0 when pend is invalid.
- flush_all (synchronous, highest priority after rst): both slots are invalidated and the state goes to IDLE. Same-cycle candidates are discarded and not counted. drop_count is kept.
- rec_ack without rec_req is ignored.

## Timing
- Reset values: rec_req=0, rec_al_ptr=0, rec_next_addr=0, busy=0, drop_count=0, state IDLE. Reset applies asynchronously on rst rise; the block releases on the first clk edge after deassertion.
- Latency: candidate sampled at edge N -> rec_req=1 in cycle N+1 (all outputs registered).
- Handshake: rec_* must stay stable while rec_req && !rec_ack, except on preemption by an older branch. The recovery manager samples data only on the ack cycle.
- busy=1 from the cycle after ack until the cycle after rec_done, inclusive of neither endpoint edge.
- Back-to-back:
  - rec_done at edge M with pend valid -> rec_req=1 in cycle M+1.
  - An ack at M+1 is legal.
- Pointer wrap: ages use modulo arithmetic. For example, head=62, ptr=1 has age 3, which is older than ptr=10 at age 12.

## Test plan
- Single mispredict: head=0, lane1 ptr=5, addr=0x1000 at cycle 1 -> rec_req=1, rec_al_ptr=5, rec_next_addr=0x1000 at cycle 2. Ack at cycle 3 -> busy=1; rec_done at cycle 6 -> IDLE, busy=0.
- Lane pick: head=0, lane0 ptr=9, lane1 ptr=4 same cycle -> rec_al_ptr=4, drop_count=1.
- Preemption, then drop:
  - With ptr=20 pending and unacked, lane0 delivers ptr=12 -> next cycle rec_al_ptr=12, drop_count unchanged.
  - Then ptr=30 arrives -> dropped, drop_count+1.
- Recovering plus older arrival: inflight ptr=20, pend empty, ptr=15 arrives -> pend holds 15 and rec_req=0. rec_done -> rec_req=1 with ptr=15 the next cycle.
- Wrap-around: head=60, pend ptr=2 (age 6); ptr=63 arrives (age 3) -> preempts; rec_al_ptr=63.
- flush_all and reset:
  - flush_all while RECOVERING with pend valid -> next cycle rec_req=0, busy=0, drop_count held.
  - Async rst asserted mid-cycle -> outputs 0 immediately.
  - Saturation: drive 65535 drops then one more -> drop_count stays 0xFFFF.
